// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage and related load/store logic.
//   mem_size encodings, FSM state constants, byte-enable bases and the
//   EX/MEM register payload.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RADD_W = 5;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Access FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Byte-enable patterns for an access at lane 0
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [RADD_W-1:0] radd;
    logic              reg_write;
    logic              read;
    logic              write;
    logic [1:0]        size;
    logic              is_unsigned;
  } ex_mem_t;

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension (combinational).
//   rdata        : raw 32-bit word from memory
//   offset       : address bits [1:0]
//   size         : mem_size encoding (11 behaves as word)
//   is_unsigned  : zero-extend instead of sign-extend
//   load_data_c  : aligned, extended load value
module mem_load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] load_data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (offset)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      MEM_BYTE: load_data_c = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      MEM_HALF: load_data_c = {{16{~is_unsigned & half_v[15]}}, half_v};
      default:  load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: EX/MEM register, req/ack data-memory port
// with timeout, and registered writeback output.
//   valid_E..mem_unsigned_E : execute-stage outputs
//   stall_M                 : hold execute and earlier stages
//   mem_req..mem_rdata      : data-memory request/ack port
//   valid_W..bus_err_W      : registered writeback entry
module memory_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_E,
  input  logic [XLEN-1:0] ALU_result_E,
  input  logic [XLEN-1:0] Write_Data_E,
  input  logic [4:0]      Radd_E,
  input  logic            reg_write_E,
  input  logic            mem_read_E,
  input  logic            mem_write_E,
  input  logic [1:0]      mem_size_E,
  input  logic            mem_unsigned_E,
  output logic            stall_M,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            valid_W,
  output logic [XLEN-1:0] result_W,
  output logic [4:0]      Radd_W,
  output logic            reg_write_W,
  output logic            misalign_W,
  output logic            bus_err_W
);

  localparam int unsigned CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

  ex_mem_t           m_q;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_byte, is_half, is_word;
  logic              misaligned, mem_op, timeout_hit, complete;
  logic [3:0]        be_base;
  logic [XLEN-1:0]   load_data;

  // Access classification of the instruction held in M
  always_comb begin
    is_byte    = (m_q.size == MEM_BYTE);
    is_half    = (m_q.size == MEM_HALF);
    is_word    = m_q.size[1];
    misaligned = m_q.valid & (m_q.read | m_q.write) &
                 ((is_half & m_q.alu[0]) | (is_word & (m_q.alu[1:0] != 2'b00)));
    mem_op     = m_q.valid & (m_q.read | m_q.write) & ~misaligned;
  end

  // FSM next state and memory-port outputs
  always_comb begin
    state_d     = state_q;
    mem_req     = mem_op;
    timeout_hit = TIMEOUT_EN & mem_req & ~mem_ack &
                  (cnt_q == CNT_W'(TIMEOUT - 1));
    complete    = ~mem_op | mem_ack | timeout_hit;
    stall_M     = mem_op & ~complete;

    case (state_q)
      ST_IDLE: if (mem_op && !complete) state_d = ST_WAIT;
      ST_WAIT: if (complete)            state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase

    // Counts consecutive request cycles; restarts for each new access
    cnt_d = (mem_req & ~complete) ? cnt_q + CNT_W'(1) : '0;

    be_base = is_byte ? BE_BYTE : (is_half ? BE_HALF : BE_WORD);
    mem_we  = mem_req & m_q.write;
    mem_be  = mem_we ? 4'(be_base << m_q.alu[1:0]) : 4'b0000;
    mem_addr = {m_q.alu[XLEN-1:2], 2'b00};
    if (is_byte)      mem_wdata = {4{m_q.wdata[7:0]}};
    else if (is_half) mem_wdata = {2{m_q.wdata[15:0]}};
    else              mem_wdata = m_q.wdata;
  end

  mem_load_align u_load_align (
    .rdata       (mem_rdata),
    .offset      (m_q.alu[1:0]),
    .size        (m_q.size),
    .is_unsigned (m_q.is_unsigned),
    .load_data_c (load_data)
  );

  // State and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX/MEM register; a bubble clears every field
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
    end else if (!stall_M) begin
      if (valid_E) begin
        m_q.valid       <= 1'b1;
        m_q.alu         <= ALU_result_E;
        m_q.wdata       <= Write_Data_E;
        m_q.radd        <= Radd_E;
        m_q.reg_write   <= reg_write_E;
        m_q.read        <= mem_read_E;
        m_q.write       <= mem_write_E;
        m_q.size        <= mem_size_E;
        m_q.is_unsigned <= mem_unsigned_E;
      end else begin
        m_q <= '0;
      end
    end
  end

  // Writeback register; bubble unless M holds an instruction that completes
  always_ff @(posedge clk) begin
    if (rst || !(complete && m_q.valid)) begin
      valid_W     <= 1'b0;
      result_W    <= '0;
      Radd_W      <= '0;
      reg_write_W <= 1'b0;
      misalign_W  <= 1'b0;
      bus_err_W   <= 1'b0;
    end else begin
      valid_W     <= 1'b1;
      if (timeout_hit)               result_W <= '0;
      else if (mem_op && m_q.read)   result_W <= load_data;
      else                           result_W <= m_q.alu;
      Radd_W      <= m_q.radd;
      reg_write_W <= m_q.reg_write & ~misaligned & ~timeout_hit;
      misalign_W  <= misaligned;
      bus_err_W   <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage (TIMEOUT=4).
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_E;
  logic [31:0] ALU_result_E, Write_Data_E;
  logic [4:0]  Radd_E;
  logic        reg_write_E, mem_read_E, mem_write_E, mem_unsigned_E;
  logic [1:0]  mem_size_E;
  logic        stall_M, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        valid_W, reg_write_W, misalign_W, bus_err_W;
  logic [31:0] result_W;
  logic [4:0]  Radd_W;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  radd;
    logic        rw;
    logic        mis;
    logic        berr;
    logic        chk_res;
  } exp_t;

  exp_t q[$];

  memory_access_stage #(.TIMEOUT(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_E(valid_E), .ALU_result_E(ALU_result_E),
    .Write_Data_E(Write_Data_E), .Radd_E(Radd_E), .reg_write_E(reg_write_E),
    .mem_read_E(mem_read_E), .mem_write_E(mem_write_E), .mem_size_E(mem_size_E),
    .mem_unsigned_E(mem_unsigned_E), .stall_M(stall_M), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_W(valid_W),
    .result_W(result_W), .Radd_W(Radd_W), .reg_write_W(reg_write_W),
    .misalign_W(misalign_W), .bus_err_W(bus_err_W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // Monitor: every writeback entry must match the oldest expected entry
  always @(negedge clk) begin
    if (valid_W === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_W got result %h radd %0d want no entry", result_W, Radd_W);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_res) chk("result_W", 64'(result_W), 64'(e.result));
        chk("Radd_W",      64'(Radd_W),      64'(e.radd));
        chk("reg_write_W", 64'(reg_write_W), 64'(e.rw));
        chk("misalign_W",  64'(misalign_W),  64'(e.mis));
        chk("bus_err_W",   64'(bus_err_W),   64'(e.berr));
      end
    end else if (rst === 1'b0) begin
      chk("w_bubble_zero",
          64'({result_W, Radd_W, reg_write_W, misalign_W, bus_err_W}), 64'(0));
    end
  end

  task automatic drive_e(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] radd,
                         input logic rw, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns);
    valid_E = 1'b1; ALU_result_E = alu; Write_Data_E = wd; Radd_E = radd;
    reg_write_E = rw; mem_read_E = rd; mem_write_E = wr; mem_size_E = sz;
    mem_unsigned_E = uns;
  endtask

  task automatic bubble_e();
    valid_E = 1'b0; ALU_result_E = '0; Write_Data_E = '0; Radd_E = '0;
    reg_write_E = 1'b0; mem_read_E = 1'b0; mem_write_E = 1'b0; mem_size_E = '0;
    mem_unsigned_E = 1'b0;
  endtask

  // Instruction that must not touch memory (ALU op or misaligned access)
  task automatic nomem_op(input logic [31:0] alu, input logic [4:0] radd, input logic rw,
                          input logic rd, input logic wr, input logic [1:0] sz, input exp_t e);
    @(negedge clk);
    drive_e(alu, 32'hCAFE_F00D, radd, rw, rd, wr, sz, 1'b0);
    q.push_back(e);
    @(negedge clk);
    bubble_e();
    #1;
    chk("nomem_req",   64'(mem_req), 64'(0));
    chk("nomem_stall", 64'(stall_M), 64'(0));
    chk("nomem_be",    64'(mem_be),  64'(0));
    @(negedge clk);
  endtask

  // Aligned access acked after 'waits' stall cycles
  task automatic mem_access(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] radd,
                            input logic rw, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns, input int waits,
                            input logic [31:0] rdata, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_be, input exp_t e);
    @(negedge clk);
    drive_e(addr, wd, radd, rw, rd, wr, sz, uns);
    q.push_back(e);
    @(negedge clk);
    bubble_e();
    for (int i = 0; i <= waits; i++) begin
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rdata : 32'h0BAD_0BAD;
      #1;
      chk("mem_req",  64'(mem_req),  64'(1));
      chk("mem_we",   64'(mem_we),   64'(wr));
      chk("mem_addr", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
      chk("mem_be",   64'(mem_be),   64'(exp_be));
      if (wr) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      chk("stall_M",  64'(stall_M),  64'(i != waits));
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    bubble_e();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", 64'({valid_W, result_W, stall_M, mem_req, mem_be, mem_we}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    rst = 1'b0;

    // ALU op
    nomem_op(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10,
             '{32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1});

    // Byte loads, signed and unsigned, zero wait
    mem_access(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0,
               32'h80FF_FF00, 32'h0, 4'b0000, '{32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1});
    mem_access(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 0,
               32'h80FF_FF00, 32'h0, 4'b0000, '{32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1});

    // Signed half load upper lane; word load with one wait cycle
    mem_access(32'h102, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 0,
               32'h80FF_FF00, 32'h0, 4'b0000, '{32'hFFFF_80FF, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1});
    mem_access(32'h104, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1,
               32'hDEAD_BEEF, 32'h0, 4'b0000, '{32'hDEAD_BEEF, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1});

    // Half store acked after 3 stall cycles
    mem_access(32'h102, 32'hABCD_1234, 5'd3, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 3,
               32'h0, 32'h1234_1234, 4'b1100, '{32'h0000_0102, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1});

    // Byte store lane 1, word store
    mem_access(32'h101, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 0,
               32'h0, 32'hA5A5_A5A5, 4'b0010, '{32'h0000_0101, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    mem_access(32'h108, 32'h1122_3344, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 0,
               32'h0, 32'h1122_3344, 4'b1111, '{32'h0000_0108, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});

    // Misaligned word load and misaligned half store
    nomem_op(32'h101, 5'd6, 1'b1, 1'b1, 1'b0, 2'b10,
             '{32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0});
    nomem_op(32'h103, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01,
             '{32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    // Timeout: request held 4 cycles, then the next instruction flows
    @(negedge clk);
    drive_e(32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    q.push_back('{32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    bubble_e();
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b0;
      #1;
      chk("to_mem_req", 64'(mem_req), 64'(1));
      chk("to_stall",   64'(stall_M), 64'(i != 3));
      if (i == 3) begin
        drive_e(32'h55, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        q.push_back('{32'h0000_0055, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1});
      end
      @(negedge clk);
    end
    bubble_e();
    #1;
    chk("to_req_dropped", 64'(mem_req), 64'(0));
    chk("to_next_stall",  64'(stall_M), 64'(0));
    repeat (2) @(negedge clk);

    // Reset during WAIT, then a stray ack while idle
    drive_e(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    bubble_e();
    #1;
    chk("rw_req",   64'(mem_req), 64'(1));
    chk("rw_stall", 64'(stall_M), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_after_rst", 64'({valid_W, stall_M, mem_req, mem_we, mem_be}), 64'(0));
    chk("rw_addr_zero", 64'(mem_addr), 64'(0));
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_no_valid", 64'(valid_W), 64'(0));
    chk("stray_ack_no_req",   64'(mem_req), 64'(0));

    nomem_op(32'h77, 5'd2, 1'b1, 1'b0, 1'b0, 2'b10,
             '{32'h0000_0077, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1});

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
Pipeline stage directly downstream of execute.
- Registers the execute outputs (ALU result, store data, destination register, control) into an EX/MEM register.
- Performs loads and stores over a req/ack data-memory port, which may be a NoC-attached memory with variable latency.
- Delivers a registered result to writeback.
- Stalls upstream while a memory access is outstanding, and aborts accesses that exceed a timeout.

Parameters:
TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before abort; 0 disables the timeout.
XLEN, 32, datapath width; only 32 supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
valid_E  in  1  execute stage presents an instruction
ALU_result_E  in  32  ALU result / effective address
Write_Data_E  in  32  store data
Radd_E  in  5  destination register
reg_write_E  in  1  instruction writes the register file
mem_read_E  in  1  load
mem_write_E  in  1  store (mem_read_E and mem_write_E never both 1)
mem_size_E  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
mem_unsigned_E  in  1  zero-extend loads
stall_M  out  1  hold execute and all earlier stages this cycle
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  store data, replicated to lanes
mem_be  out  4  byte enables
mem_ack  in  1  request completed this cycle; for loads, mem_rdata is valid in the same cycle
mem_rdata  in  32  read word
valid_W  out  1  writeback entry valid
result_W  out  32  ALU result or extended load data
Radd_W  out  5  destination register
reg_write_W  out  1  register write enable
misalign_W  out  1  access was misaligned; not issued
bus_err_W  out  1  access timed out

Behaviour:
EX/MEM register (M):
- Loads from the *_E inputs at each edge where stall_M=0.
- valid_E=0 loads a bubble.
- Holds its contents while stall_M=1.

Misalignment and memory-op detection:
- misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- mem_op = M.valid & (M.read | M.write) & ~misaligned.

FSM states: IDLE, WAIT.
- IDLE:
  - If mem_op: mem_req=1 combinationally.
    - mem_ack=1 → complete this cycle; stay in IDLE.
    - Otherwise → go to WAIT.
  - Else: M completes this cycle.
- WAIT:
  - mem_req=1 with mem_addr, mem_we, mem_wdata and mem_be held stable.
  - mem_ack=1 → complete; go to IDLE.
  - Timeout counter reaches TIMEOUT → complete with bus_err; go to IDLE.
- Timeout counter:
  - Cleared whenever mem_req is 0 or mem_ack is 1.
  - Counts cycles of mem_req=1.

Stall and latency:
- stall_M = mem_op & ~complete.
- ALU op latency: captured at edge N, valid_W at edge N+1.
- Zero-wait load: the same.
- Each wait cycle adds 1.

Writeback register (registered at the completion edge):
- valid_W = M.valid.
- result_W = load ? extended data : ALU result.
- reg_write_W = M.reg_write & ~misalign & ~timeout.
- misalign_W: set for misaligned memory ops.
  - No request is issued.
  - Completes in 1 cycle.
- bus_err_W: set on timeout.
  - result_W = 0.
- The W register gets a bubble (valid_W=0, other fields 0) when M does not complete or is empty.

Store lanes:
- byte: wdata = {4{d[7:0]}}, be = 0001<<addr[1:0].
- half: wdata = {2{d[15:0]}}, be = 0011<<addr[1:0].
- word: wdata = d, be = 1111.
- mem_be = 0 whenever mem_req = 0.

Load extraction:
- Select the byte/half at lane addr[1:0].
- Sign-extend unless unsigned.
- Word loads pass through unchanged.

Reset:
- All outputs are 0, state IDLE, counter 0, M and W registers cleared.
- Reset during WAIT:
  - mem_req drops in the cycle after reset is sampled.
  - The pending transaction is abandoned.
  - A late mem_ack while idle is ignored.

mem_ack outside mem_req: ignored.

TIMEOUT=0: never aborts.

Decomposition:
Shared package mem_pkg:
- mem_size encodings (MEM_BYTE, MEM_HALF, MEM_WORD).
- FSM state enum.
- Byte-enable base constants.

Sub-module mem_load_align:
- Combinational lane select and sign/zero extension.
- Reused by a future cache.

Test Plan:
- ALU op: valid_E=1, reg_write_E=1, ALU_result_E=0x1234, Radd_E=5 → next edge valid_W=1, result_W=0x1234, Radd_W=5; mem_req never 1; stall_M=0.
- Signed byte load: addr=0x103, mem_rdata=0x80FFFF00, ack in the same cycle → result_W=0xFFFFFF80, mem_addr=0x100, be=0; unsigned variant → 0x00000080.
- Half store: addr=0x102, data=0xABCD1234, ack after 3 cycles → mem_wdata=0x12341234, mem_be=1100, stall_M=1 for 3 cycles, signals stable throughout, valid_W one cycle after ack, reg_write_W=0.
- Misaligned word load: addr=0x101 → no mem_req, misalign_W=1, reg_write_W=0, stall_M=0.
- Timeout: TIMEOUT=4, load, no ack → mem_req high 4 cycles then drops, bus_err_W=1, result_W=0, reg_write_W=0; the next instruction then flows.
- Reset during WAIT: rst=1 for 1 cycle → mem_req=0 and all outputs 0 the following cycle; a subsequent stray mem_ack produces no valid_W.
